// File: rtl/vga_timing_rx.sv
// VGA timing receiver: recovers pixel/line coordinates from sync and blank
// strobes and locks once LOCK_FRAMES consecutive frames match the expected geometry.
module vga_timing_rx #(
    parameter int H_ACTIVE    = 1024,
    parameter int V_ACTIVE    = 768,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        blank_in,
    input  logic [11:0] pixel_in,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic [11:0] pixel_out,
    output logic        pixel_valid_out,
    output logic        frame_start_out,
    output logic        locked_out,
    output logic        error_out
);

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        LOCKED
    } state_t;

    state_t      state;
    logic        vsync_q;
    logic        blank_q;
    logic [10:0] pix_cnt;
    logic [9:0]  line_cnt;
    logic        hsync_bad;
    logic        frame_ok;
    logic [3:0]  good_frames;

    logic        vsync_rise;
    logic        blank_rise;
    logic        blank_fall;
    logic        line_good;
    logic        line_bad;
    logic [9:0]  lines_eval;
    logic        frame_good;
    logic [10:0] pix_next;
    logic [9:0]  line_next;
    logic        enter_locked;
    logic        leave_locked;
    logic        locked_next;

    assign hcount_out = pix_cnt;
    assign vcount_out = line_cnt;

    assign vsync_rise = vsync_in & ~vsync_q;
    assign blank_rise = blank_in & ~blank_q;
    assign blank_fall = ~blank_in & blank_q;

    // Line and frame conformity; a line ending on the vsync edge is counted first.
    always_comb begin
        line_good  = (({1'b0, pix_cnt} + 12'd1) == 12'(H_ACTIVE)) && !hsync_bad;
        line_bad   = blank_rise && !line_good;
        lines_eval = line_cnt;
        if (blank_rise && line_cnt != 10'd1023) begin
            lines_eval = line_cnt + 10'd1;
        end
        frame_good = frame_ok && !line_bad && ({1'b0, lines_eval} == 11'(V_ACTIVE));
    end

    always_comb begin
        pix_next = pix_cnt;
        if (blank_fall) begin
            pix_next = 11'd0;
        end else if (!blank_in && pix_cnt != 11'd2047) begin
            pix_next = pix_cnt + 11'd1;
        end
        line_next = line_cnt;
        if (vsync_rise) begin
            line_next = 10'd0;
        end else if (blank_rise) begin
            line_next = lines_eval;
        end
    end

    always_comb begin
        enter_locked = vsync_rise && frame_good &&
                       (({1'b0, good_frames} + 5'd1) >= 5'(LOCK_FRAMES));
        leave_locked = line_bad || (vsync_rise && !frame_good);
        locked_next  = ((state == LOCKED) && !leave_locked) ||
                       ((state == MEASURE) && enter_locked);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state           <= SEARCH;
            vsync_q         <= 1'b0;
            blank_q         <= 1'b0;
            pix_cnt         <= 11'd0;
            line_cnt        <= 10'd0;
            hsync_bad       <= 1'b0;
            frame_ok        <= 1'b0;
            good_frames     <= 4'd0;
            pixel_out       <= 12'd0;
            pixel_valid_out <= 1'b0;
            frame_start_out <= 1'b0;
            locked_out      <= 1'b0;
            error_out       <= 1'b0;
        end else begin
            vsync_q   <= vsync_in;
            blank_q   <= blank_in;
            pix_cnt   <= pix_next;
            line_cnt  <= line_next;
            pixel_out <= pixel_in;
            if (blank_fall) begin
                hsync_bad <= hsync_in;
            end
            if (vsync_rise) begin
                frame_ok <= 1'b1;
            end else if (line_bad) begin
                frame_ok <= 1'b0;
            end

            locked_out      <= locked_next;
            pixel_valid_out <= locked_next && !blank_in;
            frame_start_out <= locked_next && !blank_in &&
                               (pix_next == 11'd0) && (line_next == 10'd0);
            error_out       <= (state == LOCKED) && leave_locked;

            case (state)
                SEARCH: begin
                    if (vsync_rise) begin
                        state       <= MEASURE;
                        good_frames <= 4'd0;
                    end
                end
                MEASURE: begin
                    if (enter_locked) begin
                        state       <= LOCKED;
                        good_frames <= 4'd0;
                    end else if (vsync_rise) begin
                        good_frames <= frame_good ? good_frames + 4'd1 : 4'd0;
                    end
                end
                LOCKED: begin
                    if (leave_locked) begin
                        state <= SEARCH;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

endmodule
